// File: rtl/alu_sequencer_if.sv
// Request/result bundle between decode and the ALU sequencer.
interface alu_sequencer_if #(
  parameter int WIDTH  = 32,
  parameter int DISP_W = 8
);
  logic              start;
  logic [3:0]        op;
  logic [WIDTH-1:0]  operand_a;
  logic [WIDTH-1:0]  operand_b;
  logic [DISP_W-1:0] disp;
  logic [1:0]        cond;
  logic [3:0]        op_len;
  logic              busy;
  logic [WIDTH-1:0]  result;
  logic              result_valid;
  logic [1:0]        result_phase;
  logic              done;
  logic              illegal;
  logic [3:0]        flags;

  modport master (
    output start, op, operand_a, operand_b,
    output disp, cond, op_len,
    input  busy, result, result_valid,
    input  result_phase, done, illegal, flags
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    input  disp, cond, op_len,
    output busy, result, result_valid,
    output result_phase, done, illegal, flags
  );
endinterface

// File: rtl/alu_sequencer.sv
// Single-clock ALU micro-op sequencer: 1-3 registered result
// phases per op plus a persistent {OF,SF,ZF,CF} flag register.
module alu_sequencer #(
  parameter int WIDTH      = 32,
  parameter int DISP_W     = 8,
  parameter int WORD_BYTES = 4,
  parameter bit STACK_DOWN = 1'b1
) (
  input logic            clock,
  input logic            reset_n,
  alu_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, PH0, PH1, PH2
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_POP  = 4'd5;
  localparam logic [3:0] OP_JCC  = 4'd6;
  localparam logic [3:0] OP_CALL = 4'd7;
  localparam logic [3:0] OP_RET  = 4'd8;

  localparam logic [WIDTH-1:0] STEP = WIDTH'(WORD_BYTES);
  localparam int MSB = WIDTH - 1;

  state_t             state;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [DISP_W-1:0]  disp_q;
  logic [3:0]         len_q;
  logic [WIDTH-1:0]   result_q;
  logic               valid_q;
  logic [1:0]         phase_q;
  logic               done_q;
  logic               ill_q;
  logic [3:0]         flg;

  logic               idle;
  logic [3:0]         c_op;
  logic [WIDTH-1:0]   c_a;
  logic [WIDTH-1:0]   c_b;
  logic [DISP_W-1:0]  c_d;
  logic [3:0]         c_l;
  logic [WIDTH-1:0]   c_sx;
  logic [WIDTH-1:0]   c_len;
  logic [WIDTH-1:0]   sp_pop;
  logic [WIDTH-1:0]   sp_push_a;
  logic [WIDTH-1:0]   sp_push_b;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     dif;
  logic [WIDTH-1:0]   land;
  logic               of_add;
  logic               of_sub;
  logic               taken;
  logic [1:0]         ph;
  logic [1:0]         n_ph;
  logic [WIDTH-1:0]   res;
  logic               has_res;
  logic               set_f;
  logic               bad;
  logic               last;
  logic               step;
  logic [3:0]         n_flags;

  assign idle = (state == IDLE);

  // Phase 0 is computed straight from the inputs; later phases from the latch.
  always_comb begin
    c_op = idle ? bus.op        : op_q;
    c_a  = idle ? bus.operand_a : a_q;
    c_b  = idle ? bus.operand_b : b_q;
    c_d  = idle ? bus.disp      : disp_q;
    c_l  = idle ? bus.op_len    : len_q;
  end

  always_comb begin
    c_sx      = {{(WIDTH-DISP_W){c_d[DISP_W-1]}}, c_d};
    c_len     = {{(WIDTH-4){1'b0}}, c_l};
    sp_pop    = STACK_DOWN ? c_a + STEP : c_a - STEP;
    sp_push_a = STACK_DOWN ? c_a - STEP : c_a + STEP;
    sp_push_b = STACK_DOWN ? c_b - STEP : c_b + STEP;
    sum       = {1'b0, c_a} + {1'b0, c_b};
    dif       = {1'b0, c_a} - {1'b0, c_b};
    land      = c_a & c_b;
    of_add    = (c_a[MSB] == c_b[MSB]) &&
                (sum[MSB] != c_a[MSB]);
    of_sub    = (c_a[MSB] != c_b[MSB]) &&
                (dif[MSB] != c_a[MSB]);
  end

  always_comb begin
    taken = 1'b0;
    unique case (bus.cond)
      2'b00:   taken = 1'b1;
      2'b01:   taken = flg[1];
      2'b10:   taken = ~flg[1];
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    ph = 2'd2;
    unique case (state)
      IDLE:    ph = 2'd0;
      PH0:     ph = 2'd1;
      default: ph = 2'd2;
    endcase
  end

  always_comb begin
    n_ph    = 2'd1;
    res     = '0;
    has_res = 1'b0;
    set_f   = 1'b0;
    bad     = 1'b0;
    n_flags = flg;
    unique case (1'b1)
      c_op == OP_ADD: begin
        res     = sum[MSB:0];
        has_res = 1'b1;
        set_f   = 1'b1;
        n_flags = {of_add, sum[MSB],
                   ~|sum[MSB:0], sum[WIDTH]};
      end
      c_op == OP_SUB: begin
        res     = dif[MSB:0];
        has_res = 1'b1;
        set_f   = 1'b1;
        n_flags = {of_sub, dif[MSB],
                   ~|dif[MSB:0], dif[WIDTH]};
      end
      c_op == OP_AND: begin
        res     = land;
        has_res = 1'b1;
        set_f   = 1'b1;
        n_flags = {1'b0, land[MSB], ~|land, 1'b0};
      end
      c_op == OP_CMP: begin
        set_f   = 1'b1;
        n_flags = {of_sub, dif[MSB],
                   ~|dif[MSB:0], dif[WIDTH]};
      end
      c_op == OP_PUSH: begin
        n_ph    = 2'd2;
        has_res = 1'b1;
        res     = (ph == 2'd0) ? sp_push_a : c_b;
      end
      c_op == OP_POP,
      c_op == OP_RET: begin
        n_ph    = 2'd2;
        has_res = 1'b1;
        res     = (ph == 2'd0) ? c_a : sp_pop;
      end
      c_op == OP_JCC: begin
        has_res = 1'b1;
        res     = taken ? c_a + c_sx : c_a;
      end
      c_op == OP_CALL: begin
        n_ph    = 2'd3;
        has_res = 1'b1;
        unique case (ph)
          2'd0:    res = sp_push_b;
          2'd1:    res = c_a + c_len;
          default: res = c_a + c_len + c_sx;
        endcase
      end
      default: begin
        n_ph = 2'd0;
        bad  = 1'b1;
      end
    endcase
  end

  assign last = bad || (ph + 2'd1 == n_ph);
  assign step = idle ? bus.start : ~done_q;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      disp_q   <= '0;
      len_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      phase_q  <= 2'd0;
      done_q   <= 1'b0;
      ill_q    <= 1'b0;
      flg      <= '0;
    end else begin
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ill_q   <= 1'b0;
      if (step) begin
        if (idle) begin
          op_q   <= bus.op;
          a_q    <= bus.operand_a;
          b_q    <= bus.operand_b;
          disp_q <= bus.disp;
          len_q  <= bus.op_len;
        end
        if (has_res) result_q <= res;
        if (set_f) flg <= n_flags;
        valid_q <= has_res;
        phase_q <= ph;
        done_q  <= last;
        ill_q   <= bad;
        unique case (ph)
          2'd0:    state <= PH0;
          2'd1:    state <= PH1;
          default: state <= PH2;
        endcase
      end else if (!idle) begin
        state <= IDLE;
      end
    end
  end

  assign bus.busy         = ~idle;
  assign bus.result       = result_q;
  assign bus.result_valid = valid_q;
  assign bus.result_phase = phase_q;
  assign bus.done         = done_q;
  assign bus.illegal      = ill_q;
  assign bus.flags        = flg;
endmodule
